// File: rtl/mux_sweep_checker.sv
// Drives an exhaustive {S,I0,I1} sweep into a downstream 2:1 mux stage and
// compares the returned 9-bit probe vector against the ideal response.
module mux_sweep_checker #(
  parameter int PASSES = 1,
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       S,
  output logic       I0,
  output logic       I1,
  input  logic [8:0] probe,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic       first_fail_valid,
  output logic [2:0] first_fail_vec,
  output logic [8:0] first_fail_bits
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_CHECK  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [7:0] LAST_PASS   = 8'(PASSES - 1);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  logic [1:0] state;
  logic [2:0] vec;
  logic [7:0] pass_cnt;
  logic [3:0] settle_cnt;
  logic [8:0] expected;
  logic [8:0] diff;
  logic       active;
  logic       vs, vi0, vi1;

  assign vs  = vec[2];
  assign vi0 = vec[1];
  assign vi1 = vec[0];

  // Ideal response of the mux stage for the vector currently applied
  always_comb begin
    expected    = 9'd0;
    expected[0] = vi0;
    expected[1] = vi1;
    expected[2] = vs;
    expected[3] = vs;
    expected[4] = vs;
    expected[5] = 1'b0;
    expected[6] = vi1 & vs;
    expected[7] = vi0 & ~vs;
    expected[8] = vs ? vi1 : vi0;
  end

  assign diff   = probe ^ expected;
  assign active = (state == ST_SETTLE) || (state == ST_CHECK);

  assign S    = active & vs;
  assign I0   = active & vi0;
  assign I1   = active & vi1;
  assign busy = active;
  assign done = (state == ST_DONE);
  assign pass = (err_count == 8'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= ST_IDLE;
      vec              <= 3'd0;
      pass_cnt         <= 8'd0;
      settle_cnt       <= 4'd0;
      err_count        <= 8'd0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= 3'd0;
      first_fail_bits  <= 9'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            vec              <= 3'd0;
            pass_cnt         <= 8'd0;
            settle_cnt       <= 4'd0;
            err_count        <= 8'd0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= 3'd0;
            first_fail_bits  <= 9'd0;
            state            <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= ST_CHECK;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        ST_CHECK: begin
          // One error per failing vector regardless of how many bits differ
          if (diff != 9'd0) begin
            if (err_count != 8'hFF) begin
              err_count <= err_count + 8'd1;
            end
            if (!first_fail_valid) begin
              first_fail_valid <= 1'b1;
              first_fail_vec   <= vec;
              first_fail_bits  <= diff;
            end
          end
          if ((vec == 3'd7) && (pass_cnt == LAST_PASS)) begin
            state <= ST_DONE;
          end else begin
            if (vec == 3'd7) begin
              pass_cnt <= pass_cnt + 8'd1;
            end
            vec        <= vec + 3'd1;
            settle_cnt <= 4'd0;
            state      <= ST_SETTLE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_sweep_checker.sv
// Directed bench for mux_sweep_checker: three instances cover the default,
// long-run saturation and long-settle configurations.
module tb_mux_sweep_checker;

  logic clk = 1'b0;
  logic clkEn = 1'b0;
  logic rst = 1'b0;
  logic start1 = 1'b0, start2 = 1'b0, start3 = 1'b0;
  logic model1 = 1'b0;
  int   ph3 = 0;
  int   checks = 0;
  int   fails = 0;

  logic       s1, i01, i11, busy1, done1, pass1, ffv1;
  logic [7:0] err1;
  logic [2:0] ffvec1;
  logic [8:0] ffbits1, probe1;

  logic       s2, i02, i12, busy2, done2, pass2, ffv2;
  logic [7:0] err2;
  logic [2:0] ffvec2;
  logic [8:0] ffbits2, probe2;

  logic       s3, i03, i13, busy3, done3, pass3, ffv3;
  logic [7:0] err3;
  logic [2:0] ffvec3;
  logic [8:0] ffbits3, probe3;

  function automatic logic [8:0] idealOut(input logic s, input logic i0, input logic i1);
    logic [8:0] r;
    r = {(s ? i1 : i0), (i0 & ~s), (i1 & s), 1'b0, s, s, s, i1, i0};
    return r;
  endfunction

  function automatic logic [8:0] faultyOut(input logic s, input logic i0, input logic i1);
    logic [8:0] r;
    r = idealOut(s, i0, i1);
    r[7] = 1'b0;
    r[8] = i1 & s;
    return r;
  endfunction

  assign probe1 = model1 ? faultyOut(s1, i01, i11) : idealOut(s1, i01, i11);
  assign probe2 = 9'h1FF;
  assign probe3 = (busy3 && (ph3 % 4 != 0)) ? 9'h1FF : idealOut(s3, i03, i13);

  // Cycle index within a dut3 run: 1 in the first SETTLE cycle, CHECK on multiples of 4
  always @(posedge clk) begin
    if (start3 && !busy3 && !rst) ph3 <= 1;
    else ph3 <= ph3 + 1;
  end

  always begin
    #5;
    if (clkEn) clk = ~clk;
  end

  mux_sweep_checker dut1 (
    .clk(clk), .rst(rst), .start(start1), .S(s1), .I0(i01), .I1(i11), .probe(probe1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_fail_valid(ffv1), .first_fail_vec(ffvec1), .first_fail_bits(ffbits1));

  mux_sweep_checker #(.PASSES(200)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .S(s2), .I0(i02), .I1(i12), .probe(probe2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .first_fail_valid(ffv2), .first_fail_vec(ffvec2), .first_fail_bits(ffbits2));

  mux_sweep_checker #(.SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .S(s3), .I0(i03), .I1(i13), .probe(probe3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
    .first_fail_valid(ffv3), .first_fail_vec(ffvec3), .first_fail_bits(ffbits3));

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Leaves the caller at the falling edge inside the first SETTLE cycle
  task automatic applyStimulus(input int which);
    @(negedge clk);
    case (which)
      1: start1 = 1'b1;
      2: start2 = 1'b1;
      default: start3 = 1'b1;
    endcase
    @(negedge clk);
    start1 = 1'b0;
    start2 = 1'b0;
    start3 = 1'b0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_dut1"}, {busy1, done1, pass1, err1, ffv1, ffvec1, ffbits1, s1, i01, i11},
                {1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 3'd0, 9'd0, 3'd0});
    checkOutput({tag, "_dut2"}, {busy2, done2, pass2, err2, ffv2, ffvec2, ffbits2, s2, i02, i12},
                {1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 3'd0, 9'd0, 3'd0});
    checkOutput({tag, "_dut3"}, {busy3, done3, pass3, err3, ffv3, ffvec3, ffbits3, s3, i03, i13},
                {1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 3'd0, 9'd0, 3'd0});
  endtask

  initial begin
    logic sawDone;
    logic [2:0] expVec;

    // Reset with no clock running
    #1 rst = 1'b1;
    #1 checkResetValues("reset_noclk");
    clkEn = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checkOutput("idle_hold", {busy1, done1, pass1, err1, ffv1, s1, i01, i11},
                  {1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 3'd0});
    end
    checkResetValues("idle_hold_all");

    $display("[TB] clean sweep, default parameters");
    applyStimulus(1);
    for (int k = 1; k <= 18; k++) begin
      if (k <= 16) begin
        expVec = 3'((k - 1) / 2);
        checkOutput("clean_busy", {busy1, done1}, 2'b10);
        checkOutput("clean_vec", {s1, i01, i11}, expVec);
      end else if (k == 17) begin
        checkOutput("clean_done", {busy1, done1, s1, i01, i11}, 5'b01000);
        checkOutput("clean_result", {pass1, err1, ffv1}, {1'b1, 8'd0, 1'b0});
      end else begin
        checkOutput("clean_after", {busy1, done1, pass1}, 3'b001);
      end
      @(negedge clk);
    end

    $display("[TB] faulty mux model, default parameters");
    model1 = 1'b1;
    applyStimulus(1);
    for (int k = 1; k <= 17; k++) begin
      if (k == 17) begin
        checkOutput("fault_done", done1, 1'b1);
        checkOutput("fault_err", err1, 8'd2);
        checkOutput("fault_ffv", ffv1, 1'b1);
        checkOutput("fault_ffvec", ffvec1, 3'b010);
        checkOutput("fault_ffbits", ffbits1, 9'h180);
        checkOutput("fault_pass", pass1, 1'b0);
      end
      @(negedge clk);
    end
    checkOutput("fault_hold", {pass1, err1, ffv1, ffvec1, ffbits1},
                {1'b0, 8'd2, 1'b1, 3'b010, 9'h180});

    $display("[TB] saturation, PASSES=200 with stuck probe");
    applyStimulus(2);
    sawDone = 1'b0;
    for (int k = 1; k <= 3202; k++) begin
      if (k < 3201 && done2) sawDone = 1'b1;
      if (k == 600) checkOutput("sat_mid", err2, 8'd255);
      if (k == 3201) begin
        checkOutput("sat_early_done", sawDone, 1'b0);
        checkOutput("sat_done", done2, 1'b1);
        checkOutput("sat_err", err2, 8'd255);
        checkOutput("sat_ff", {ffv2, ffvec2, ffbits2}, {1'b1, 3'd0, 9'h1FF});
        checkOutput("sat_pass", pass2, 1'b0);
      end
      if (k == 3202) checkOutput("sat_idle", {busy2, done2}, 2'b00);
      @(negedge clk);
    end

    $display("[TB] SETTLE=3 with glitching probe and extra starts");
    applyStimulus(3);
    for (int k = 1; k <= 36; k++) begin
      start3 = (k == 5 || k == 20);
      if (k == 2) checkOutput("glitch_busy", busy3, 1'b1);
      if (k == 32) checkOutput("glitch_pre_done", {busy3, done3}, 2'b10);
      if (k == 33) checkOutput("glitch_done", {busy3, done3, pass3, err3}, {3'b011, 8'd0});
      if (k == 34 || k == 36) checkOutput("glitch_no_requeue", {busy3, done3}, 2'b00);
      @(negedge clk);
    end
    start3 = 1'b0;
    checkOutput("glitch_ffv", ffv3, 1'b0);

    $display("[TB] reset during vector 4 CHECK");
    model1 = 1'b1;
    applyStimulus(1);
    for (int k = 1; k < 10; k++) @(negedge clk);
    checkOutput("abort_pre_vec", {busy1, s1, i01, i11}, 4'b1100);
    checkOutput("abort_pre_err", err1, 8'd2);
    rst = 1'b1;
    #1 checkResetValues("abort_reset");
    @(negedge clk);
    rst = 1'b0;
    sawDone = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done1 || busy1) sawDone = 1'b1;
    end
    checkOutput("abort_no_done", sawDone, 1'b0);
    model1 = 1'b0;
    applyStimulus(1);
    for (int k = 1; k <= 17; k++) begin
      if (k == 17) checkOutput("rerun_done", {done1, pass1, err1, ffv1}, {2'b11, 8'd0, 1'b0});
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
